// File: rtl/controle_servo_pkg.sv
// Shared definitions for the servo sweep sequencer: FSM state encoding,
// position limits and a helper used to size the cycle counters.
package controle_servo_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    AGUARDA  = 3'd1,
    PULSO    = 3'd2,
    CONFIRMA = 3'd3,
    MANUAL   = 3'd4
  } estado_t;

  localparam logic [1:0] POS_MIN = 2'd0;
  localparam logic [1:0] POS_MAX = 2'd3;

  // Largest of three timing parameters; all counters share one width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/controle_servo_varredura_contador_ciclos.sv
// Saturating cycle counter. 'zera' clears, 'conta' advances, 'fim' is high
// while the count sits at LIMITE-1, so a state that counts from a cleared
// counter and leaves on 'fim' lasts exactly LIMITE cycles. Never wraps.
module contador_ciclos
  import controle_servo_pkg::*;
#(
  parameter int W      = 8,
  parameter int LIMITE = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [W-1:0] cnt_q, cnt_d;

  assign fim = (cnt_q == W'(LIMITE - 1));

  // Next count: clear has priority, then hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (zera)
      cnt_d = '0;
    else if (conta && !fim)
      cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/controle_servo_varredura.sv
// Servo sweep sequencer: emits direita/esquerda step pulses to circuito_pwm,
// either as an automatic 0->3->0 sweep or as single manual steps, and uses
// the fed-back 'pos' to confirm each step and to reverse at the ends.
// Optional build macro: CONTROLE_SERVO_TIMEOUT_EN adds a confirmation
// timeout that raises the sticky 'erro' flag and requires a 0->1 toggle of
// 'ligar' before the sweep may restart.
module controle_servo_varredura
  import controle_servo_pkg::*;
#(
  parameter int DWELL_CYCLES   = 50000000,
  parameter int PULSE_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       manual_dir,
  input  logic       manual_esq,
  input  logic [1:0] pos,
  output logic       direita,
  output logic       esquerda,
  output logic       fim_ciclo,
  output logic       erro,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(max3(DWELL_CYCLES, PULSE_CYCLES, TIMEOUT_CYCLES)) + 1;

  estado_t    estado_q, estado_d;
  logic       sentido_q, sentido_d;
  logic [1:0] pos_ant_q, pos_ant_d;
  logic       atingiu_max_q, atingiu_max_d;
  logic       direita_q, direita_d;
  logic       esquerda_q, esquerda_d;
  logic       fim_ciclo_q, fim_ciclo_d;
  logic       erro_q, erro_d;
  logic       dir_ant_q, esq_ant_q;
  logic       sobe_dir, sobe_esq;
  logic       fim_dwell, fim_pulso;
  logic       partida;

  assign sobe_dir = manual_dir & ~dir_ant_q;
  assign sobe_esq = manual_esq & ~esq_ant_q;

  contador_ciclos #(.W(CW), .LIMITE(DWELL_CYCLES)) u_dwell (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q != AGUARDA),
    .conta (estado_q == AGUARDA),
    .fim   (fim_dwell)
  );

  contador_ciclos #(.W(CW), .LIMITE(PULSE_CYCLES)) u_pulso (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q != PULSO),
    .conta (estado_q == PULSO),
    .fim   (fim_pulso)
  );

`ifdef CONTROLE_SERVO_TIMEOUT_EN
  logic armado_q, armado_d;
  logic fim_timeout;

  contador_ciclos #(.W(CW), .LIMITE(TIMEOUT_CYCLES)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q != CONFIRMA),
    .conta (estado_q == CONFIRMA),
    .fim   (fim_timeout)
  );

  // After a timeout the sweep stays parked until ligar has been seen low.
  assign partida = ligar & armado_q;
`else
  assign partida = ligar;
`endif

  // Next state, direction bookkeeping and registered-output precompute.
  always_comb begin
    estado_d      = estado_q;
    sentido_d     = sentido_q;
    pos_ant_d     = pos_ant_q;
    atingiu_max_d = atingiu_max_q;
    fim_ciclo_d   = 1'b0;
    erro_d        = erro_q;
`ifdef CONTROLE_SERVO_TIMEOUT_EN
    armado_d      = armado_q | ~ligar;
`endif

    case (estado_q)
      OCIOSO: begin
        if (partida) begin
          estado_d = AGUARDA;
        end else if (!ligar && (sobe_dir ^ sobe_esq)) begin
          // Simultaneous rising edges are treated as no request.
          sentido_d = sobe_dir;
          estado_d  = MANUAL;
        end
      end

      AGUARDA: begin
        if (!ligar) begin
          estado_d = OCIOSO;
        end else if (fim_dwell) begin
          if (pos == POS_MAX)      sentido_d = 1'b0;
          else if (pos == POS_MIN) sentido_d = 1'b1;
          estado_d = PULSO;
        end
      end

      MANUAL: begin
        // A step past either end stop is dropped without a pulse.
        if ((sentido_q && pos == POS_MAX) || (!sentido_q && pos == POS_MIN))
          estado_d = OCIOSO;
        else
          estado_d = PULSO;
      end

      PULSO: begin
        if (fim_pulso) estado_d = CONFIRMA;
      end

      CONFIRMA: begin
        if (pos != pos_ant_q) begin
          if (pos == POS_MAX) atingiu_max_d = 1'b1;
          if (pos == POS_MIN && atingiu_max_q) begin
            fim_ciclo_d   = 1'b1;
            atingiu_max_d = 1'b0;
          end
          estado_d = ligar ? AGUARDA : OCIOSO;
        end
`ifdef CONTROLE_SERVO_TIMEOUT_EN
        else if (fim_timeout) begin
          erro_d   = 1'b1;
          armado_d = 1'b0;
          estado_d = OCIOSO;
        end
`endif
      end

      default: estado_d = OCIOSO;
    endcase

    // Snapshot the position on entry to PULSO so a plant that moves during
    // the pulse is still confirmed against the pre-step value.
    if (estado_d == PULSO && estado_q != PULSO)
      pos_ant_d = pos;

    // Outputs are registered and follow the state being entered, so the
    // pulse is high exactly for the cycles spent in PULSO.
    direita_d  = (estado_d == PULSO) &  sentido_d;
    esquerda_d = (estado_d == PULSO) & ~sentido_d;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      sentido_q     <= 1'b1;
      pos_ant_q     <= POS_MIN;
      atingiu_max_q <= 1'b0;
      direita_q     <= 1'b0;
      esquerda_q    <= 1'b0;
      fim_ciclo_q   <= 1'b0;
      erro_q        <= 1'b0;
      dir_ant_q     <= 1'b0;
      esq_ant_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      sentido_q     <= sentido_d;
      pos_ant_q     <= pos_ant_d;
      atingiu_max_q <= atingiu_max_d;
      direita_q     <= direita_d;
      esquerda_q    <= esquerda_d;
      fim_ciclo_q   <= fim_ciclo_d;
      erro_q        <= erro_d;
      dir_ant_q     <= manual_dir;
      esq_ant_q     <= manual_esq;
    end
  end

`ifdef CONTROLE_SERVO_TIMEOUT_EN
  // Sweep re-arm flag.
  always_ff @(posedge clock) begin
    if (reset) armado_q <= 1'b1;
    else       armado_q <= armado_d;
  end
`endif

  assign direita   = direita_q;
  assign esquerda  = esquerda_q;
  assign fim_ciclo = fim_ciclo_q;
  assign erro      = erro_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_servo_varredura.sv
// Bench for controle_servo_varredura with a behavioural circuito_pwm plant.
// Stimulus pushes expected pulse / fim_ciclo events into a queue; a monitor
// measures every event the DUT produces and pops the queue to compare.
module tb_controle_servo_varredura;

  localparam int DW = 100;
  localparam int PW = 20;
  localparam int TW = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       manual_dir = 1'b0;
  logic       manual_esq = 1'b0;
  logic [1:0] pos;
  logic       direita, esquerda, fim_ciclo, erro;
  logic [2:0] db_estado;

  logic stuck = 1'b0;
  logic dir_prev, esq_prev;

  int checks = 0;
  int errors = 0;

  typedef enum int {EV_DIR, EV_ESQ, EV_FIM} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       largura;
  } ev_t;
  ev_t esperado[$];

  controle_servo_varredura #(
    .DWELL_CYCLES  (DW),
    .PULSE_CYCLES  (PW),
    .TIMEOUT_CYCLES(TW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ligar     (ligar),
    .manual_dir(manual_dir),
    .manual_esq(manual_esq),
    .pos       (pos),
    .direita   (direita),
    .esquerda  (esquerda),
    .fim_ciclo (fim_ciclo),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Plant: one position step per rising edge of a step pulse, clamped 0..3.
  always @(posedge clock) begin
    if (reset) begin
      pos      <= 2'd0;
      dir_prev <= 1'b0;
      esq_prev <= 1'b0;
    end else begin
      dir_prev <= direita;
      esq_prev <= esquerda;
      if (!stuck) begin
        if (direita && !dir_prev && pos != 2'd3)       pos <= pos + 2'd1;
        else if (esquerda && !esq_prev && pos != 2'd0) pos <= pos - 2'd1;
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int w);
    ev_t e;
    e.kind    = k;
    e.largura = w;
    esperado.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int w);
    ev_t e;
    checks++;
    if (esperado.size() == 0) begin
      errors++;
      $display("FAIL evento_inesperado: got kind %0d width %0d expected none", k, w);
    end else begin
      e = esperado.pop_front();
      if (e.kind != k || e.largura != w) begin
        errors++;
        $display("FAIL evento: got kind %0d width %0d expected kind %0d width %0d",
                 k, w, e.kind, e.largura);
      end
    end
  endtask

  // Monitor: measures pulse widths and fim_ciclo strobes away from the edge.
  int       run_w = 0;
  logic     run_dir = 1'b0;
  logic     in_pulse = 1'b0;
  int       fim_w = 0;
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (direita && esquerda) begin
        errors++;
        $display("FAIL exclusao: got direita=1 esquerda=1 expected at most one");
      end
    end
    if (direita || esquerda) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        run_dir  = direita;
        run_w    = 0;
      end
      run_w++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      observe(run_dir ? EV_DIR : EV_ESQ, run_w);
    end
    if (fim_ciclo) fim_w++;
    else if (fim_w > 0) begin
      observe(EV_FIM, fim_w);
      fim_w = 0;
    end
  end

  // Manual request held 20 cycles, then released and allowed to settle.
  task automatic passo(input logic d, input logic e);
    manual_dir = d;
    manual_esq = e;
    repeat (20) @(negedge clock);
    manual_dir = 1'b0;
    manual_esq = 1'b0;
    repeat (30) @(negedge clock);
  endtask

  int n;

  initial begin
    // Reset held for 20 cycles.
    repeat (20) @(negedge clock);
    chk("rst_direita",  direita,   0);
    chk("rst_esquerda", esquerda,  0);
    chk("rst_fim",      fim_ciclo, 0);
    chk("rst_erro",     erro,      0);
    chk("rst_estado",   db_estado, 0);
    chk("rst_pos",      pos,       0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Full sweep 0->3->0.
    push(EV_DIR, PW); push(EV_DIR, PW); push(EV_DIR, PW);
    push(EV_ESQ, PW); push(EV_ESQ, PW); push(EV_ESQ, PW);
    push(EV_FIM, 1);
    ligar = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!direita && n < 500);
    chk("lat_varredura", n, DW + 1);
    n = 0;
    while (!fim_ciclo && n < 3000) begin @(negedge clock); n++; end
    chk("fim_visto", fim_ciclo, 1);
    chk("fim_pos", pos, 0);
    ligar = 1'b0;
    repeat (5) @(negedge clock);
    chk("pos_varredura_fim", pos, 0);
    chk("ocioso_apos_varredura", db_estado, 0);
    repeat (200) @(negedge clock);

    // Manual stepping right: 1, 2, 3, then dropped at 3.
    push(EV_DIR, PW);
    manual_dir = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!direita && n < 10);
    chk("lat_manual", n, 2);
    repeat (20 - n) @(negedge clock);
    manual_dir = 1'b0;
    repeat (30) @(negedge clock);
    chk("manual_pos1", pos, 1);
    push(EV_DIR, PW);
    passo(1'b1, 1'b0);
    chk("manual_pos2", pos, 2);
    push(EV_DIR, PW);
    passo(1'b1, 1'b0);
    chk("manual_pos3", pos, 3);
    passo(1'b1, 1'b0);
    chk("manual_pos3_limite", pos, 3);
    chk("manual_limite_estado", db_estado, 0);
    passo(1'b1, 1'b1);
    chk("manual_ambos", pos, 3);
    push(EV_ESQ, PW);
    passo(1'b0, 1'b1);
    chk("manual_esq_pos2", pos, 2);

    // Sweep stopped mid-pulse: pulse completes, then idle.
    push(EV_ESQ, PW);
    ligar = 1'b1;
    n = 0;
    while (!(direita || esquerda) && n < 500) begin @(negedge clock); n++; end
    chk("parada_pulso_visto", esquerda, 1);
    repeat (5) @(negedge clock);
    ligar = 1'b0;
    repeat (300) @(negedge clock);
    chk("parada_estado", db_estado, 0);
    chk("parada_pos", pos, 1);

`ifdef CONTROLE_SERVO_TIMEOUT_EN
    // Confirmation timeout with the plant stuck at pos=1.
    stuck = 1'b1;
    push(EV_ESQ, PW);
    ligar = 1'b1;
    n = 0;
    while (!esquerda && n < 500) begin @(negedge clock); n++; end
    n = 0;
    while (!erro && n < 1000) begin @(negedge clock); n++; end
    chk("timeout_latencia", n, PW + TW);
    chk("timeout_estado", db_estado, 0);
    repeat (300) @(negedge clock);
    chk("timeout_sem_reinicio", db_estado, 0);
    chk("timeout_erro_fixo", erro, 1);
    ligar = 1'b0;
    stuck = 1'b0;
    repeat (5) @(negedge clock);
`else
    chk("erro_desligado", erro, 0);
`endif

    // Reset on cycle 10 of a manual left pulse.
    push(EV_ESQ, 10);
    manual_esq = 1'b1;
    n = 0;
    while (!esquerda && n < 10) begin @(negedge clock); n++; end
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_meio_esquerda", esquerda, 0);
    chk("rst_meio_direita", direita, 0);
    chk("rst_meio_estado", db_estado, 0);
    chk("rst_meio_sentido", dut.sentido_q, 1);
    chk("rst_meio_erro", erro, 0);
    chk("rst_meio_pos", pos, 0);
    reset = 1'b0;
    manual_esq = 1'b0;
    repeat (20) @(negedge clock);

    chk("fila_vazia", esperado.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
